// File: rtl/ula_multiciclo.sv
// Registered multi-cycle ALU for the nRISC datapath: start/ready handshake, one-cycle
// logic/add/sub/shift ops, optional iterative shift-add MUL built when ULA_MUL_EN is defined.
module ula_multiciclo #(
    parameter int WIDTH = 8
) (
    input  logic             c,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       ULAOp,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             ready,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] result_hi,
    output logic             zero,
    output logic             carry,
    output logic             overflow,
    output logic             negative,
    output logic [1:0]       dbg_state_o
);

    localparam int SHW = $clog2(WIDTH);

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_OR  = 3'b010;
    localparam logic [2:0] OP_AND = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_SLL = 3'b101;
    localparam logic [2:0] OP_SRL = 3'b110;
    localparam logic [2:0] OP_MUL = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        MULT = 2'd2
    } state_t;

    state_t           state_q;
    logic [2:0]       op_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] result_q;
    logic [WIDTH-1:0] result_hi_q;
    logic             zero_q;
    logic             carry_q;
    logic             overflow_q;
    logic             negative_q;
    logic             done_q;

    logic [WIDTH:0]   add_w;
    logic [WIDTH:0]   sub_w;
    logic [WIDTH-1:0] result_d;
    logic             carry_d;
    logic             overflow_d;
    logic             zero_d;
    logic             negative_d;

    // Add/sub at WIDTH+1 bits: the top bit is ADD carry-out or SUB unsigned borrow.
    assign add_w = {1'b0, a_q} + {1'b0, b_q};
    assign sub_w = {1'b0, a_q} - {1'b0, b_q};

    always_comb begin
        result_d   = '0;
        carry_d    = 1'b0;
        overflow_d = 1'b0;
        case (op_q)
            OP_ADD: begin
                result_d   = add_w[WIDTH-1:0];
                carry_d    = add_w[WIDTH];
                overflow_d = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (add_w[WIDTH-1] != a_q[WIDTH-1]);
            end
            OP_SUB: begin
                result_d   = sub_w[WIDTH-1:0];
                carry_d    = sub_w[WIDTH];
                overflow_d = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (sub_w[WIDTH-1] != a_q[WIDTH-1]);
            end
            OP_OR:   result_d = a_q | b_q;
            OP_AND:  result_d = a_q & b_q;
            OP_XOR:  result_d = a_q ^ b_q;
            OP_SLL:  result_d = a_q << b_q[SHW-1:0];
            OP_SRL:  result_d = a_q >> b_q[SHW-1:0];
            default: result_d = '0; // MUL reaching EXEC only when the multiplier is not built
        endcase
    end

    assign zero_d     = (result_d == '0);
    assign negative_d = result_d[WIDTH-1];

`ifdef ULA_MUL_EN
    logic [SHW-1:0]     cnt_q;
    logic [2*WIDTH-1:0] acc_q;
    logic [2*WIDTH-1:0] partial_d;
    logic [2*WIDTH-1:0] acc_d;

    // Step i adds multiplicand<<i when multiplier bit i is set.
    assign partial_d = b_q[cnt_q] ? ({{WIDTH{1'b0}}, a_q} << cnt_q) : '0;
    assign acc_d     = acc_q + partial_d;
`endif

    always_ff @(posedge c or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            op_q        <= '0;
            a_q         <= '0;
            b_q         <= '0;
            result_q    <= '0;
            result_hi_q <= '0;
            zero_q      <= 1'b0;
            carry_q     <= 1'b0;
            overflow_q  <= 1'b0;
            negative_q  <= 1'b0;
            done_q      <= 1'b0;
`ifdef ULA_MUL_EN
            cnt_q       <= '0;
            acc_q       <= '0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        op_q <= ULAOp;
                        a_q  <= a;
                        b_q  <= b;
`ifdef ULA_MUL_EN
                        if (ULAOp == OP_MUL) begin
                            state_q <= MULT;
                            cnt_q   <= '0;
                            acc_q   <= '0;
                        end else begin
                            state_q <= EXEC;
                        end
`else
                        state_q <= EXEC;
`endif
                    end
                end
                EXEC: begin
                    result_q    <= result_d;
                    result_hi_q <= '0;
                    zero_q      <= zero_d;
                    carry_q     <= carry_d;
                    overflow_q  <= overflow_d;
                    negative_q  <= negative_d;
                    done_q      <= 1'b1;
                    state_q     <= IDLE;
                end
`ifdef ULA_MUL_EN
                MULT: begin
                    acc_q <= acc_d;
                    cnt_q <= cnt_q + SHW'(1);
                    if (cnt_q == SHW'(WIDTH - 1)) begin
                        result_q    <= acc_d[WIDTH-1:0];
                        result_hi_q <= acc_d[2*WIDTH-1:WIDTH];
                        zero_q      <= (acc_d == '0);
                        carry_q     <= 1'b0;
                        overflow_q  <= 1'b0;
                        negative_q  <= acc_d[2*WIDTH-1];
                        done_q      <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
`endif
                default: state_q <= IDLE;
            endcase
        end
    end

    // Handshake: an op is accepted on a rising edge of c with start=1 and ready=1;
    // done pulses for exactly the cycle in which result and flags change.
    assign ready       = (state_q == IDLE);
    assign done        = done_q;
    assign result      = result_q;
    assign result_hi   = result_hi_q;
    assign zero        = zero_q;
    assign carry       = carry_q;
    assign overflow    = overflow_q;
    assign negative    = negative_q;
    assign dbg_state_o = state_q;

endmodule
